// File: rtl/m68k_bus_pkg.sv
// rtl/m68k_bus_pkg.sv - shared state, mode and region-entry types for the 68000 bus decoder
package m68k_bus_pkg;

   localparam int ADDR_W   = 24;
   localparam int WS_MAX_W = 8;

   localparam logic [1:0] MODE_ANY = 2'b00;
   localparam logic [1:0] MODE_RO  = 2'b01;
   localparam logic [1:0] MODE_WO  = 2'b10;
   localparam logic [1:0] MODE_OFF = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_WAIT,
      ST_ACK,
      ST_ERR
   } state_t;

   // Fields are stored at the widest supported size; narrower configs zero-extend,
   // so unused upper mask bits are zero and the upper address bits mirror.
   typedef struct packed {
      logic [ADDR_W-1:0]   base;
      logic [ADDR_W-1:0]   mask;
      logic [WS_MAX_W-1:0] ws;
      logic [1:0]          mode;
   } region_t;

   // True when the access direction (rw=1 read) is allowed by the region mode
   function automatic logic mode_permits(input logic [1:0] mode, input logic rw);
      case (mode)
         MODE_ANY: return 1'b1;
         MODE_RO:  return rw;
         MODE_WO:  return !rw;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/m68k_region_match.sv
// rtl/m68k_region_match.sv - per-region address comparators with lowest-index priority select
module m68k_region_match
   import m68k_bus_pkg::*;
#(
   parameter int N_REG = 16,
   parameter int WS_W  = 4
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              rw_i,
   input  region_t           regions_i [N_REG],
   output logic              hit_o,
   output logic [4:0]        idx_o,
   output logic [N_REG-1:0]  cs_o,
   output logic [WS_W-1:0]   ws_o
);

   logic [N_REG-1:0] match;

   // One masked compare per region, qualified by the region's direction mode
   always_comb begin
      match = '0;
      for (int i = 0; i < N_REG; i++) begin
         match[i] = (((addr_i ^ regions_i[i].base) & regions_i[i].mask) == '0)
                    && mode_permits(regions_i[i].mode, rw_i);
      end
   end

   // Scan from the top down so the lowest matching index is the one left standing
   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      cs_o  = '0;
      ws_o  = '0;
      for (int i = N_REG - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit_o    = 1'b1;
            idx_o    = 5'(i);
            cs_o     = '0;
            cs_o[i]  = 1'b1;
            ws_o     = regions_i[i].ws[WS_W-1:0];
         end
      end
   end

endmodule

// File: rtl/m68k_bus_decode.sv
// rtl/m68k_bus_decode.sv - 68000 chip-select decoder with wait states; M68K_BUS_DECODE_BERR_EN enables bus-error timeout
module m68k_bus_decode
   import m68k_bus_pkg::*;
#(
   parameter int N_REG  = 16,
   parameter int DEC_W  = 20,
   parameter int WS_W   = 4,
   parameter int TO_CYC = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [23:0]       cpu_a,
   input  logic              cpu_as_n,
   input  logic              cpu_rw,
   input  logic              cfg_we,
   input  logic [4:0]        cfg_idx,
   input  logic [DEC_W-1:0]  cfg_base,
   input  logic [DEC_W-1:0]  cfg_mask,
   input  logic [WS_W-1:0]   cfg_ws,
   input  logic [1:0]        cfg_mode,
   output logic [N_REG-1:0]  cs,
   output logic [4:0]        hit_idx,
   output logic              hit,
   output logic              dtack_n,
   output logic              berr_n
);

   region_t          regions_q [N_REG];
   state_t           state_q;
   logic [N_REG-1:0] cs_q;
   logic [4:0]       hit_idx_q;
   logic             hit_q;
   logic             dtack_n_q;
   logic [WS_W-1:0]  wait_q;

   logic             m_hit;
   logic [4:0]       m_idx;
   logic [N_REG-1:0] m_cs;
   logic [WS_W-1:0]  m_ws;

`ifdef M68K_BUS_DECODE_BERR_EN
   localparam int TO_W = $clog2(TO_CYC + 1);
   logic [TO_W-1:0]  to_q;
   logic             berr_n_q;
`endif

   m68k_region_match #(
      .N_REG (N_REG),
      .WS_W  (WS_W)
   ) u_match (
      .addr_i    (cpu_a),
      .rw_i      (cpu_rw),
      .regions_i (regions_q),
      .hit_o     (m_hit),
      .idx_o     (m_idx),
      .cs_o      (m_cs),
      .ws_o      (m_ws)
   );

   // Region table: out-of-range indices simply match no entry; DECODE sees the pre-write value
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_REG; i++) begin
            regions_q[i] <= '{base: '0, mask: '0, ws: '0, mode: MODE_OFF};
         end
      end else if (cfg_we) begin
         for (int i = 0; i < N_REG; i++) begin
            if (cfg_idx == 5'(i)) begin
               regions_q[i] <= '{base: ADDR_W'(cfg_base), mask: ADDR_W'(cfg_mask),
                                 ws: WS_MAX_W'(cfg_ws), mode: cfg_mode};
            end
         end
      end
   end

   // Bus-cycle FSM: selection and wait count are latched once in DECODE and held to the end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cs_q      <= '0;
         hit_idx_q <= '0;
         hit_q     <= 1'b0;
         dtack_n_q <= 1'b1;
         wait_q    <= '0;
`ifdef M68K_BUS_DECODE_BERR_EN
         to_q      <= '0;
         berr_n_q  <= 1'b1;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!cpu_as_n) state_q <= ST_DECODE;
            end
            ST_DECODE: begin
               if (cpu_as_n) begin
                  state_q <= ST_IDLE;
               end else if (m_hit) begin
                  cs_q      <= m_cs;
                  hit_idx_q <= m_idx;
                  hit_q     <= 1'b1;
                  wait_q    <= m_ws;
                  state_q   <= (m_ws != '0) ? ST_WAIT : ST_ACK;
               end else begin
                  cs_q      <= '0;
                  hit_idx_q <= '0;
                  hit_q     <= 1'b0;
                  wait_q    <= '0;
`ifdef M68K_BUS_DECODE_BERR_EN
                  to_q      <= '0;
`endif
                  state_q   <= ST_ERR;
               end
            end
            ST_WAIT: begin
               if (cpu_as_n) begin
                  state_q   <= ST_IDLE;
                  cs_q      <= '0;
                  hit_idx_q <= '0;
                  hit_q     <= 1'b0;
                  wait_q    <= '0;
               end else if (wait_q <= WS_W'(1)) begin
                  wait_q  <= '0;
                  state_q <= ST_ACK;
               end else begin
                  wait_q <= wait_q - WS_W'(1);
               end
            end
            ST_ACK: begin
               if (cpu_as_n) begin
                  state_q   <= ST_IDLE;
                  cs_q      <= '0;
                  hit_idx_q <= '0;
                  hit_q     <= 1'b0;
                  dtack_n_q <= 1'b1;
               end else begin
                  dtack_n_q <= 1'b0;
               end
            end
            ST_ERR: begin
`ifdef M68K_BUS_DECODE_BERR_EN
               if (cpu_as_n) begin
                  state_q  <= ST_IDLE;
                  to_q     <= '0;
                  berr_n_q <= 1'b1;
               end else if (to_q == TO_W'(TO_CYC)) begin
                  berr_n_q <= 1'b0;
               end else begin
                  to_q <= to_q + TO_W'(1);
               end
`else
               // Open-bus: an unmapped access is simply acknowledged like a zero-wait hit
               if (cpu_as_n) begin
                  state_q   <= ST_IDLE;
                  dtack_n_q <= 1'b1;
               end else begin
                  dtack_n_q <= 1'b0;
               end
`endif
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cs      = cs_q;
   assign hit_idx = hit_idx_q;
   assign hit     = hit_q;
   assign dtack_n = dtack_n_q;
`ifdef M68K_BUS_DECODE_BERR_EN
   assign berr_n  = berr_n_q;
`else
   assign berr_n  = 1'b1;
`endif

endmodule

// File: tb/tb_m68k_bus_decode.sv
// tb/tb_m68k_bus_decode.sv - vector table plus scoreboard bench for m68k_bus_decode
module tb_m68k_bus_decode;

   localparam int N_REG  = 16;
   localparam int DEC_W  = 20;
   localparam int WS_W   = 4;
   localparam int TO_CYC = 64;
`ifdef M68K_BUS_DECODE_BERR_EN
   localparam bit BERR_EN  = 1'b1;
   localparam int MISS_LAT = TO_CYC + 2;
`else
   localparam bit BERR_EN  = 1'b0;
   localparam int MISS_LAT = 2;
`endif
   localparam int BUDGET = TO_CYC + 40;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [23:0]       cpu_a = '0;
   logic              cpu_as_n = 1'b1;
   logic              cpu_rw = 1'b1;
   logic              cfg_we = 1'b0;
   logic [4:0]        cfg_idx = '0;
   logic [DEC_W-1:0]  cfg_base = '0;
   logic [DEC_W-1:0]  cfg_mask = '0;
   logic [WS_W-1:0]   cfg_ws = '0;
   logic [1:0]        cfg_mode = '0;
   logic [N_REG-1:0]  cs;
   logic [4:0]        hit_idx;
   logic              hit;
   logic              dtack_n;
   logic              berr_n;

   m68k_bus_decode #(
      .N_REG(N_REG), .DEC_W(DEC_W), .WS_W(WS_W), .TO_CYC(TO_CYC)
   ) dut (
      .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_as_n(cpu_as_n), .cpu_rw(cpu_rw),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_mask(cfg_mask),
      .cfg_ws(cfg_ws), .cfg_mode(cfg_mode), .cs(cs), .hit_idx(hit_idx), .hit(hit),
      .dtack_n(dtack_n), .berr_n(berr_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] a;
      logic        rw;
      logic        hit;
      logic [4:0]  idx;
      int          ws;
   } vec_t;

   typedef struct {
      logic             hit;
      logic [4:0]       idx;
      logic [N_REG-1:0] cs;
      int               lat;
      logic             berr;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[12];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic cfg_write(input logic [4:0] idx, input logic [DEC_W-1:0] base,
                            input logic [DEC_W-1:0] mask, input logic [WS_W-1:0] ws,
                            input logic [1:0] mode);
      @(negedge clk);
      cfg_idx = idx; cfg_base = base; cfg_mask = mask; cfg_ws = ws; cfg_mode = mode;
      cfg_we = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic expect_access(input logic hit_e, input logic [4:0] idx_e, input int ws_e);
      exp_t e;
      e.hit  = hit_e;
      e.idx  = hit_e ? idx_e : 5'd0;
      e.cs   = '0;
      if (hit_e) e.cs[idx_e] = 1'b1;
      e.lat  = hit_e ? 2 + ws_e : MISS_LAT;
      e.berr = !hit_e && BERR_EN;
      sb.push_back(e);
   endtask

   // Runs one complete bus cycle; optionally rewrites region 0 with new_ws at cycle cfg_lat
   task automatic do_access(input string name, input logic [23:0] a, input logic rw,
                            input int cfg_lat, input logic [WS_W-1:0] new_ws);
      exp_t e;
      int   lat;
      bit   got;
      @(negedge clk);
      cpu_a = a; cpu_rw = rw; cpu_as_n = 1'b0;
      lat = -1;
      got = 1'b0;
      while (!got && lat < BUDGET) begin
         @(negedge clk);
         lat++;
         cfg_we = 1'b0;
         if (lat == cfg_lat) begin
            cfg_idx = 5'd0; cfg_base = '0; cfg_mask = 20'hF8000; cfg_ws = new_ws;
            cfg_mode = 2'b00; cfg_we = 1'b1;
         end
         if (lat == 1 && sb.size() != 0) check({name, " cs@1"}, 32'(cs), 32'(sb[0].cs));
         got = (!dtack_n || !berr_n);
      end
      cfg_we = 1'b0;
      check({name, " sb"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({name, " done"}, 32'(got), 32'd1);
         if (got) begin
            check({name, " lat"}, 32'(lat), 32'(e.lat));
            check({name, " berr_n"}, 32'(berr_n), 32'(!e.berr));
            check({name, " dtack_n"}, 32'(dtack_n), 32'(e.berr));
            check({name, " hit"}, 32'(hit), 32'(e.hit));
            check({name, " idx"}, 32'(hit_idx), 32'(e.idx));
            check({name, " cs"}, 32'(cs), 32'(e.cs));
         end
      end
      cpu_as_n = 1'b1;
      @(negedge clk);
      check({name, " rel"}, {28'd0, dtack_n, berr_n, hit, |cs}, 32'b1100);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit dt_low;

      vecs[0]  = '{24'h007FFE, 1'b1, 1'b1, 5'd0, 0};
      vecs[1]  = '{24'h188010, 1'b1, 1'b1, 5'd2, 3};
      vecs[2]  = '{24'h0F0000, 1'b1, 1'b1, 5'd1, 1};
      vecs[3]  = '{24'h0F0ABC, 1'b0, 1'b1, 5'd1, 1};
      vecs[4]  = '{24'h040010, 1'b0, 1'b0, 5'd0, 0};
      vecs[5]  = '{24'h040010, 1'b1, 1'b1, 5'd3, 0};
      vecs[6]  = '{24'h060004, 1'b0, 1'b1, 5'd6, 1};
      vecs[7]  = '{24'h060004, 1'b1, 1'b0, 5'd0, 0};
      vecs[8]  = '{24'h070000, 1'b1, 1'b0, 5'd0, 0};
      vecs[9]  = '{24'h050000, 1'b1, 1'b1, 5'd4, 15};
      vecs[10] = '{24'hA07FFE, 1'b1, 1'b1, 5'd0, 0};
      vecs[11] = '{24'h388010, 1'b0, 1'b1, 5'd2, 3};

      repeat (3) @(negedge clk);
      check("reset outs", {25'd0, dtack_n, berr_n, hit, hit_idx}, {25'd0, 2'b11, 1'b0, 5'd0});
      check("reset cs", 32'(cs), 32'd0);
      reset = 1'b0;

      expect_access(1'b0, 5'd0, 0);
      do_access("unprogrammed", 24'h007FFE, 1'b1, -1, '0);

      cfg_write(5'd0,  20'h00000, 20'hF8000, 4'd0,  2'b00);
      cfg_write(5'd2,  20'h88000, 20'hFF800, 4'd3,  2'b00);
      cfg_write(5'd1,  20'hF0000, 20'hF0000, 4'd1,  2'b00);
      cfg_write(5'd5,  20'hF0000, 20'hFF000, 4'd2,  2'b00);
      cfg_write(5'd3,  20'h40000, 20'hFF000, 4'd0,  2'b01);
      cfg_write(5'd4,  20'h50000, 20'hFF000, 4'd15, 2'b00);
      cfg_write(5'd6,  20'h60000, 20'hFF000, 4'd1,  2'b10);
      cfg_write(5'd7,  20'h70000, 20'hFF000, 4'd2,  2'b11);
      cfg_write(5'd20, 20'h50000, 20'hFF000, 4'd0,  2'b11);

      for (int i = 0; i < 12; i++) begin
         expect_access(vecs[i].hit, vecs[i].idx, vecs[i].ws);
         do_access($sformatf("vec%0d", i), vecs[i].a, vecs[i].rw, -1, '0);
      end

      // Table write during WAIT keeps the latched count; the next cycle sees the new one
      cfg_write(5'd0, 20'h00000, 20'hF8000, 4'd3, 2'b00);
      expect_access(1'b1, 5'd0, 3);
      do_access("cfg_in_wait", 24'h001000, 1'b1, 2, 4'd1);
      expect_access(1'b1, 5'd0, 1);
      do_access("cfg_new_ws", 24'h001000, 1'b1, -1, '0);
      // Write landing on the DECODE edge: DECODE still sees the old entry
      expect_access(1'b1, 5'd0, 1);
      do_access("cfg_at_decode", 24'h001000, 1'b1, 0, 4'd4);
      expect_access(1'b1, 5'd0, 4);
      do_access("cfg_after", 24'h001000, 1'b1, -1, '0);

      // Abort in WAIT: AS released at cycle 4 of a ws=7 access
      cfg_write(5'd8, 20'h20000, 20'hFF000, 4'd7, 2'b00);
      @(negedge clk);
      cpu_a = 24'h020000; cpu_rw = 1'b1; cpu_as_n = 1'b0;
      dt_low = 1'b0;
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         if (!dtack_n) dt_low = 1'b1;
      end
      check("abort cs before", 32'(cs), 32'h100);
      cpu_as_n = 1'b1;
      @(negedge clk);
      check("abort cs", 32'(cs), 32'd0);
      check("abort hit", 32'(hit), 32'd0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (!dtack_n) dt_low = 1'b1;
      end
      check("abort no dtack", 32'(dt_low), 32'd0);

      // Reset pulsed mid-WAIT
      @(negedge clk);
      cpu_a = 24'h020000; cpu_rw = 1'b1; cpu_as_n = 1'b0;
      repeat (4) @(negedge clk);
      check("wait idx", 32'(hit_idx), 32'd8);
      reset = 1'b1;
      @(negedge clk);
      check("midrst outs", {25'd0, dtack_n, berr_n, hit, hit_idx}, {25'd0, 2'b11, 1'b0, 5'd0});
      check("midrst cs", 32'(cs), 32'd0);
      cpu_as_n = 1'b1;
      reset = 1'b0;

      // Reset also cleared the table
      expect_access(1'b0, 5'd0, 0);
      do_access("post_rst_r0", 24'h007FFE, 1'b1, -1, '0);
      expect_access(1'b0, 5'd0, 0);
      do_access("post_rst_r8", 24'h020000, 1'b1, -1, '0);

      check("sb empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/m68k_bus_decode.md
M68K_BUS_DECODE -- requirements
Module: m68k_bus_decode

Interface
REQ-001 SHALL have parameter N_REG, default 16, meaning number of decode regions (1..32).
REQ-002 SHALL have parameter DEC_W, default 20, meaning number of low address bits decoded; upper bits ignored (mirroring).
REQ-003 SHALL have parameter WS_W, default 4, meaning width of the per-region wait-state count.
REQ-004 SHALL have parameter TO_CYC, default 64, meaning the unmapped-access timeout in clk cycles.
REQ-005 SHALL have ports, in this order:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- cpu_a  in  24  CPU address.
- cpu_as_n  in  1  address strobe, active low.
- cpu_rw  in  1  1 = read.
- cfg_we  in  1  region-table write strobe.
- cfg_idx  in  5  region index.
- cfg_base  in  DEC_W  region base.
- cfg_mask  in  DEC_W  compare mask (1 = bit compared).
- cfg_ws  in  WS_W  wait states.
- cfg_mode  in  2  00 = any, 01 = read-only, 10 = write-only, 11 = disabled.
- cs  out  N_REG  registered one-hot chip select.
- hit_idx  out  5  index of the selected region.
- hit  out  1  a region is selected.
- dtack_n  out  1  data acknowledge, active low.
- berr_n  out  1  bus error, active low.

Function
REQ-006 SHALL match region i when ((cpu_a[DEC_W-1:0] ^ base_i) & mask_i) == 0, mode_i != 11, and cpu_rw is permitted by mode_i.
REQ-007 SHALL resolve multiple matches by priority: the lowest index wins; cs SHALL never have more than one bit set.
REQ-008 SHALL implement an FSM with states IDLE, DECODE, WAIT, ACK and ERR.
REQ-009 IDLE: a sampled cpu_as_n=0 SHALL transition to DECODE.
REQ-010 DECODE: SHALL latch cs/hit_idx/hit and load the wait counter with ws of the winning region in one cycle; on hit, go to WAIT if ws>0, else ACK; on miss, go to ERR.
REQ-011 WAIT: SHALL decrement the counter each cycle and enter ACK on the cycle after it reaches 1, giving exactly ws extra cycles; AS-to-dtack latency SHALL be 2+ws cycles.
REQ-012 ACK: dtack_n SHALL be 0 and cs held until cpu_as_n is sampled 1, then return to IDLE with cs=0, hit=0 and dtack_n=1 on the next cycle.
REQ-013 cpu_as_n sampled 1 in DECODE, WAIT or ERR SHALL abort the cycle to IDLE, clear cs and never assert dtack_n.
REQ-014 cpu_a and cpu_rw changes after DECODE SHALL not affect cs until the next bus cycle.
REQ-015 cfg_we SHALL write table entry cfg_idx on the clock edge; writes with cfg_idx >= N_REG SHALL be ignored.
REQ-016 A table write takes effect from the next DECODE; an in-flight cycle SHALL keep its latched selection and wait count.
REQ-017 A cfg_we to the same index that DECODE reads in that cycle SHALL present the old entry to DECODE.
REQ-018 ws = all-ones SHALL produce 2^WS_W-1 waits without counter wrap.

Reset
REQ-019 While reset is high, SHALL hold: FSM = IDLE, cs=0, hit=0, hit_idx=0, dtack_n=1, berr_n=1, wait and timeout counters = 0.
REQ-020 Reset SHALL set every region to mode 11 (disabled), base 0, mask 0, ws 0.
REQ-021 Reset asserted mid-cycle SHALL abandon the cycle immediately with no dtack or berr pulse.

Configuration
REQ-022 SHALL use the macro M68K_BUS_DECODE_BERR_EN to control unmapped-access handling.
REQ-023 With the macro defined, ERR SHALL count TO_CYC cycles, then assert berr_n=0 until cpu_as_n is sampled 1; dtack_n stays 1 throughout.
REQ-024 Without the macro, ERR SHALL behave as ACK with ws=0 (open-bus dtack), berr_n SHALL be tied to 1, and the timeout counter SHALL be absent.

Structure
REQ-025 A shared package m68k_bus_pkg SHALL hold the state enum, the mode encodings (MODE_ANY, MODE_RO, MODE_WO, MODE_OFF) and the region-entry struct (base, mask, ws, mode).
REQ-026 The priority match SHALL be a sub-module m68k_region_match (N_REG comparators plus a lowest-index encoder, purely combinational); the FSM, counters and table SHALL reside in the top level.

Verification
REQ-027 Program region 0 base 0x00000, mask 0xF8000 (ROM, ws 0); read 0x07FFE -> cs[0]=1 after 1 cycle, dtack_n=0 at cycle 2, released 1 cycle after AS rises.
REQ-028 Program region 2 base 0x88000, mask 0xFF800, ws 3; read 0x188010 (mirror) -> cs[2]=1, dtack_n low at cycle 5.
REQ-029 Program overlapping regions 1 and 5 both covering 0x0F0000; access -> hit_idx=1 only, and cs is one-hot.
REQ-030 Make region 3 read-only; write to its address -> miss; with BERR_EN, berr_n=0 after TO_CYC+2 cycles; without, dtack_n=0 at cycle 2.
REQ-031 Set ws 7, deassert AS at cycle 4 -> IDLE next cycle, dtack_n never low, cs=0; then pulse reset during a WAIT -> all outputs at reset values on the following cycle.
REQ-032 Issue cfg_we on region 0 during its WAIT -> current cycle completes with old ws; the next access uses the new ws.
